// File: rtl/s2p_frame_ctrl.sv
// Serial-to-parallel frame controller: counts WIDTH qualified bits after sof and hands the word off over valid/ready.
// Optional even-parity trailer bit when S2P_PARITY_EN is defined.
module s2p_frame_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serin,
  input  logic             bit_valid,
  input  logic             sof,
  output logic             shift_en,
  output logic             busy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef S2P_PARITY_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] buffer;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             slot_free;

  // Any valid bit is taken once a frame is open; in IDLE only a sof opens one.
  assign shift_en  = bit_valid & ((state != IDLE) | sof);
  assign busy      = (state != IDLE);
  assign shifted   = {buffer[WIDTH-2:0], serin};
  assign slot_free = ~out_valid | out_ready;

`ifdef S2P_PARITY_EN
  logic parity_reg;
  assign complete   = shift_en & ~sof & (state == PAR);
  assign word       = buffer;
  assign parity_err = parity_reg;
`else
  assign complete   = shift_en & ~sof & (state == SHIFT) & (cnt == LAST);
  assign word       = shifted;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      buffer    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef S2P_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (shift_en) begin
        if (sof) begin
          // A sof inside an open frame discards it and restarts on this bit.
          buffer    <= shifted;
          cnt       <= CNT_W'(1);
          state     <= SHIFT;
          frame_err <= (state != IDLE);
        end else if (state == SHIFT) begin
          buffer <= shifted;
          if (cnt == LAST) begin
`ifdef S2P_PARITY_EN
            state <= PAR;
            cnt   <= cnt + CNT_W'(1);
`else
            state <= IDLE;
            cnt   <= '0;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          state <= IDLE;
          cnt   <= '0;
        end
      end

      if (complete && slot_free) begin
        out_data  <= word;
        out_valid <= 1'b1;
`ifdef S2P_PARITY_EN
        parity_reg <= (^buffer) ^ serin;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (complete && !slot_free) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Directed bench for s2p_frame_ctrl (WIDTH=8); parity vectors run only when S2P_PARITY_EN is defined.
module tb_s2p_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       serin;
  logic       bit_valid;
  logic       sof;
  logic       shift_en;
  logic       busy;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int n_checks = 0;
  int n_fail   = 0;
  int se_cnt   = 0;
  logic busy_ok;

  always #5 clk = ~clk;

  s2p_frame_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .serin(serin), .bit_valid(bit_valid), .sof(sof),
    .shift_en(shift_en), .busy(busy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Drive one qualified bit; returns #1 after the sampling edge.
  task automatic send_bit(input logic b, input logic s);
    serin = b; sof = s; bit_valid = 1'b1;
    @(negedge clk);
    if (shift_en) se_cnt++;
    @(posedge clk); #1;
    bit_valid = 1'b0; sof = 1'b0; serin = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (shift_en) se_cnt++;
      busy_ok = busy_ok & busy;
      @(posedge clk); #1;
    end
  endtask

  // MSB first, sof on the first bit; gap idle cycles between bits; parity bit p when enabled.
  task automatic send_word(input logic [7:0] w, input int gap, input logic p);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], i == 7);
`ifdef S2P_PARITY_EN
      busy_ok = busy_ok & busy;
      if (gap > 0) idle(gap);
`else
      if (i > 0) begin
        busy_ok = busy_ok & busy;
        if (gap > 0) idle(gap);
      end
`endif
    end
`ifdef S2P_PARITY_EN
    send_bit(p, 1'b0);
`else
    if (p) busy_ok = busy_ok;
`endif
  endtask

  initial begin
    rst = 1'b1; serin = 1'b0; bit_valid = 1'b0; sof = 1'b0; out_ready = 1'b1;
    busy_ok = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);
    check("rst_shift_en", {31'd0, shift_en}, 32'd0);
    @(posedge clk); #1;

    // 1: A5, no gaps
    send_word(8'hA5, 0, 1'b0);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_data", {24'd0, out_data}, 32'h0A5);
    idle(1);
    check("t1_cleared", {31'd0, out_valid}, 32'd0);

    // 2: 3C with 3-cycle gaps
    se_cnt = 0; busy_ok = 1'b1;
    send_word(8'h3C, 3, 1'b0);
`ifdef S2P_PARITY_EN
    check("t2_shift_en_count", se_cnt, 32'd9);
`else
    check("t2_shift_en_count", se_cnt, 32'd8);
`endif
    check("t2_busy", {31'd0, busy_ok}, 32'd1);
    check("t2_data", {24'd0, out_data}, 32'h03C);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_idle_after", {31'd0, busy}, 32'd0);
    idle(1);

    // 3: 5-bit partial frame aborted by a fresh FF frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    check("t3_frame_err", {31'd0, frame_err}, 32'd1);
    check("t3_no_partial", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
`ifdef S2P_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    check("t3_data", {24'd0, out_data}, 32'h0FF);
    check("t3_valid", {31'd0, out_valid}, 32'd1);
    check("t3_frame_err_clear", {31'd0, frame_err}, 32'd0);
    idle(1);

    // 4: overrun with out_ready low
    out_ready = 1'b0;
    send_word(8'h11, 0, 1'b0);
    check("t4_first", {24'd0, out_data}, 32'h011);
    send_word(8'h22, 0, 1'b0);
    check("t4_overrun", {31'd0, overrun}, 32'd1);
    check("t4_held", {24'd0, out_data}, 32'h011);
    idle(1);
    check("t4_overrun_pulse", {31'd0, overrun}, 32'd0);
    check("t4_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    idle(1);
    check("t4_consumed", {31'd0, out_valid}, 32'd0);

    // 5: async reset mid-frame with a word held
    out_ready = 1'b0;
    send_word(8'h55, 0, 1'b0);
    check("t5_held", {24'd0, out_data}, 32'h055);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_data", {24'd0, out_data}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    idle(2);
    check("t5_nothing_emitted", {31'd0, out_valid}, 32'd0);
    send_word(8'h0F, 0, 1'b0);
    check("t5_data", {24'd0, out_data}, 32'h00F);
    check("t5_valid", {31'd0, out_valid}, 32'd1);
    idle(1);

`ifdef S2P_PARITY_EN
    // 6: parity trailer
    send_word(8'hA5, 0, 1'b0);
    check("t6_valid0", {31'd0, out_valid}, 32'd1);
    check("t6_data0", {24'd0, out_data}, 32'h0A5);
    check("t6_perr0", {31'd0, parity_err}, 32'd0);
    send_word(8'hA5, 0, 1'b1);
    check("t6_valid1", {31'd0, out_valid}, 32'd1);
    check("t6_perr1", {31'd0, parity_err}, 32'd1);
    idle(1);
`else
    check("parity_tied", {31'd0, parity_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/s2p_frame_ctrl.md
Name: s2p_frame_ctrl

Overview:
Frame controller for the serial-to-parallel shift path. It detects a start-of-frame strobe and counts WIDTH serial bits into an internal shift buffer, gating each shift with a per-bit valid. It then transfers the completed word to a holding register offered downstream over a valid/ready handshake. It also flags aborted frames and overruns, and exports its shift enable so an external s2p datapath can be driven in lockstep.

Parameters:
WIDTH, 8, data bits per frame; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
serin  input  1  serial data bit, sampled only when bit_valid=1
bit_valid  input  1  serin carries a valid bit this cycle
sof  input  1  start of frame; qualified by bit_valid; the bit carried with it is data bit 0
shift_en  output  1  combinational; =1 in any cycle a bit is accepted into the buffer
busy  output  1  frame in progress (state != IDLE)
out_data  output  WIDTH  assembled word; first-received bit at MSB
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  downstream accepts out_data when out_valid & out_ready
frame_err  output  1  1-cycle pulse: frame aborted by a new sof
overrun  output  1  1-cycle pulse: completed word dropped, holding register full
parity_err  output  1  parity mismatch flag for the word in out_data; see Optional Feature

Behaviour:
- Reset (async, rst=1): state=IDLE; bit counter=0; buffer=0; out_data=0; out_valid=0; frame_err=0; overrun=0; parity_err=0; busy=0.
- Reset mid-frame or with out_valid=1: the partial frame and the held word are discarded. Nothing is emitted after release.
- States: IDLE, SHIFT, PAR (PAR exists only with the macro).
- IDLE:
  - bit_valid & sof: shift serin in, cnt=1, go SHIFT.
  - bit_valid without sof: ignore; shift_en=0.
- SHIFT:
  - bit_valid & ~sof: buffer={buffer[WIDTH-2:0],serin}; cnt++.
  - bit_valid & sof: abort. Pulse frame_err next cycle. Restart with this bit as bit 0: buffer={..,serin}, cnt=1, stay SHIFT. No word is emitted.
  - bit_valid=0: hold all state; gaps of any length are legal.
  - When the accepted bit makes cnt==WIDTH: without the macro, complete the frame (see below) and go IDLE with cnt=0. With the macro, go PAR.
- Completion (the cycle the last bit is accepted; registered effect next cycle):
  - Slot free = ~out_valid | out_ready in that cycle.
  - If free: out_data <= final word (including the bit just shifted); out_valid <= 1.
  - If not free: word dropped; overrun pulses 1 cycle; out_data and out_valid unchanged.
- Latency: out_valid rises on the clock edge after the edge that samples the last data bit (parity bit when the macro is set).
- Handshake:
  - out_data is stable while out_valid=1.
  - out_valid clears on out_valid & out_ready unless a new word loads in the same cycle, in which case it stays 1 with the new data.
- Back-to-back: sof with the first bit of the next frame is legal in the cycle right after the last bit. IDLE accepts it, so there are zero idle cycles between frames.
- frame_err and overrun never assert in the same cycle for the same frame. Both are registered.

Optional Feature:
Macro S2P_PARITY_EN.
- Defined:
  - After WIDTH data bits, the FSM enters PAR. The next bit_valid bit is an even-parity bit over the data word.
  - The parity bit is not shifted into the buffer, but shift_en=1 for it.
  - Completion happens on that bit. parity_err <= (^word ^ paritybit) and is loaded alongside out_data, so it is valid while out_valid=1.
  - sof in PAR aborts exactly as in SHIFT.
- Undefined: no PAR state; frames are WIDTH bits; parity_err is tied 0.

Test Plan:
1. Reset, then frame 1,0,1,0,0,1,0,1 (sof on first bit, no gaps), out_ready=1. Expect out_data=8'hA5 and out_valid=1 one cycle after the last bit; cleared the next cycle.
2. Frame 8'h3C with bit_valid=0 gaps of 3 cycles between bits. Expect shift_en=1 on exactly 8 cycles, out_data=8'h3C, busy=1 throughout the frame.
3. 5 bits, then sof with a fresh frame 8'hFF. Expect a frame_err pulse, then out_data=8'hFF with no word from the partial frame.
4. out_ready=0; send 8'h11 then 8'h22 back-to-back. Expect out_data to stay 8'h11 and an overrun pulse after bit 16. Raise out_ready: 8'h11 is consumed and out_valid=0.
5. Assert rst mid-frame at bit 4, with out_valid=1 holding 8'h55. Expect all outputs 0 immediately (async). A following frame 8'h0F yields 8'h0F.
6. With S2P_PARITY_EN: send 8'hA5 + parity 0, expect parity_err=0. Send 8'hA5 + parity 1, expect parity_err=1. Each word appears one cycle after its parity bit.
